full_adder_bist: RTL and testbench
==================================

# full_adder_bist

Hardware self-test controller for a single-bit full adder: drives `a`, `b` and `carryin` into a full-adder instance, samples its `sum` and `carryout`, and checks them against the full-adder truth table. On request, it sweeps all 8 input vectors, holding each for a programmable settle time. It then reports pass/fail, the mismatch count and the first failing vector. It is the synthesizable stimulus/check end of the full-adder interface, used for on-chip checking of gate-level adder cells.

## Interface
- `SETTLE_CYCLES`, 4: clock cycles each vector is held before its response is sampled; legal range 1..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a sweep when sampled high in IDLE; ignored otherwise.
- `a`  out  1  operand A to the adder under test.
- `b`  out  1  operand B to the adder under test.
- `carryin`  out  1  carry-in to the adder under test.
- `sum`  in  1  sum returned by the adder under test.
- `carryout`  in  1  carry-out returned by the adder under test.
- `busy`  out  1  high while the sweep is in progress.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `pass`  out  1  high when the last completed sweep had zero mismatches; held until the next `done`.
- `err_count`  out  4  number of mismatching vectors in the current or last sweep (0..8).
- `first_fail`  out  3  index of the first mismatching vector; 0 when `err_count`=0.

## Operation
- States:
  - IDLE: `busy`=0, drive outputs 0.
  - RUN: `busy`=1, drive outputs from the vector index `vec`.
  - DONE: one cycle, `done`=1, `busy`=0, drive outputs 0.
- Vector encoding: `vec`[0]=`a`, `vec`[1]=`b`, `vec`[2]=`carryin`. Order is `vec`=0,1,…,7, so `a` toggles fastest.
- Expected values:
  - `sum` = `a`^`b`^`carryin`.
  - `carryout` = majority(`a`,`b`,`carryin`).
  - A vector mismatches if either output differs from its expected value.
- IDLE→RUN on `start`=1:
  - `vec`←0, settle counter←0.
  - `err_count`←0, `first_fail`←0.
- RUN:
  - The settle counter increments each cycle.
  - When counter=`SETTLE_CYCLES`-1, on that edge, `sum` and `carryout` are compared.
  - On a mismatch: `err_count`+1. If this is the first mismatch, `first_fail`←`vec`.
  - The counter then resets, and `vec` increments; after `vec`=7, the next state is DONE.
- DONE→IDLE unconditionally.
  - `pass` is set to (`err_count`==0) on entry to DONE, including the update from vector 7.
- `start` during RUN or DONE: ignored, with no restart and no queuing.
- `err_count` saturates at 8, which is also the maximum reachable value.
- Reset mid-sweep: the next state is IDLE, all outputs take their reset values, and no `done` pulse is issued.

## Timing
- Reset values:
  - `a`, `b`, `carryin`, `busy`, `done`, `pass` = 0.
  - `err_count` = 0, `first_fail` = 0.
- Let E0 be the edge at which `start` is sampled. Drive outputs are registered.
  - Vector k is driven from after edge E0+k·S through edge E0+(k+1)·S, where S=`SETTLE_CYCLES`.
  - The response to vector k is sampled at edge E0+(k+1)·S. The adder must settle within S cycles.
- `done` is high for exactly the one cycle after edge E0+8·S. `pass`, `err_count` and `first_fail` are valid from that cycle and hold until the next `start`.
- `busy` is high from after E0 through edge E0+8·S.
- Minimum start-to-start spacing is 8·S+2 cycles.
- Simultaneous `reset` and `start`: reset wins.

## Configuration
- `FULL_ADDER_BIST_STOP_ON_FAIL_EN`:
  - Defined: the sweep terminates at the first mismatch. The FSM goes from RUN to DONE after that vector's sample edge, with `err_count`=1, `first_fail`=failing `vec`, `pass`=0. `done` follows at edge E0+(k+1)·S, where k is the failing vector.
  - Undefined: all 8 vectors are always applied, and `err_count` reflects the total number of mismatches.

## Test plan
- Reset held 2 cycles, then released with `start`=0 → all outputs 0 and remain 0 for 50 cycles.
- Correct behavioural full adder attached, S=4, `start` pulse →
  - `a`/`b`/`carryin` step through vectors 0..7, 4 cycles each.
  - `done` appears after edge E0+32.
  - `pass`=1, `err_count`=0, `first_fail`=0.
- Adder with `carryout` stuck at 0 → mismatches at vectors 3,5,6,7; `err_count`=4, `first_fail`=3, `pass`=0.
- Adder with inverted `sum` → `err_count`=8, `first_fail`=0, `pass`=0.
- Second `start` pulse at E0+5 → ignored.
  - Reset asserted at E0+10 → `busy`=0 next cycle, no `done`.
  - New `start` → full sweep, `done` after 32 edges.
- `FULL_ADDER_BIST_STOP_ON_FAIL_EN` defined, `carryout` stuck at 0, S=4 → `done` after edge E0+16, `err_count`=1, `first_fail`=3, `pass`=0.

Source files
------------

// File: rtl/full_adder_bist_if.sv
// Bundle between the full-adder BIST controller and its surroundings.
// master: the BIST controller (drives stimulus and status, reads responses and start).
// slave : the environment (adder under test plus requester).
//   start       request a sweep
//   a/b/carryin stimulus to the adder under test
//   sum/carryout response from the adder under test
//   busy/done   sweep status, done is a one-cycle pulse
//   pass        last completed sweep had no mismatches
//   err_count   mismatching vectors (0..8)
//   first_fail  index of the first mismatching vector
interface full_adder_bist_if;
  logic       start;
  logic       a;
  logic       b;
  logic       carryin;
  logic       sum;
  logic       carryout;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;

  modport master (
    input  start, sum, carryout,
    output a, b, carryin, busy, done, pass, err_count, first_fail
  );

  modport slave (
    output start, sum, carryout,
    input  a, b, carryin, busy, done, pass, err_count, first_fail
  );
endinterface

// File: rtl/full_adder_bist.sv
// Self-test controller for a single-bit full adder. On start it sweeps the
// 8 input vectors (vec[0]=a, vec[1]=b, vec[2]=carryin), holds each for
// SETTLE_CYCLES clocks, samples sum/carryout on the last held edge and
// compares against the full-adder truth table.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    full_adder_bist_if.master (start, stimulus, response, status)
// Parameter:
//   SETTLE_CYCLES  cycles each vector is held before sampling, 1..255
// Build option:
//   FULL_ADDER_BIST_STOP_ON_FAIL_EN  when defined, the sweep ends at the
//   first mismatching vector.
module full_adder_bist #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  full_adder_bist_if.master   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [7:0] LastCnt = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [2:0] first_q, first_d;
  logic       pass_q, pass_d;
  logic [2:0] drv_q, drv_d;

  logic exp_sum, exp_co, mismatch, stop;

  always_comb begin
    exp_sum  = ^vec_q;
    exp_co   = (vec_q[0] & vec_q[1]) | (vec_q[0] & vec_q[2]) | (vec_q[1] & vec_q[2]);
    mismatch = (bus.sum != exp_sum) || (bus.carryout != exp_co);
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    stop    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          vec_d   = 3'd0;
          cnt_d   = 8'd0;
          err_d   = 4'd0;
          first_d = 3'd0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LastCnt) begin
          cnt_d = 8'd0;
          vec_d = vec_q + 3'd1;
          if (mismatch) begin
            if (err_q != 4'd8) err_d = err_q + 4'd1;
            if (err_q == 4'd0) first_d = vec_q;
`ifdef FULL_ADDER_BIST_STOP_ON_FAIL_EN
            stop = 1'b1;
`else
            stop = 1'b0;
`endif
          end
          if (vec_q == 3'd7 || stop) begin
            state_d = StDone;
            // pass reflects the count including this last sample
            pass_d  = (err_d == 4'd0);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Stimulus is registered so the adder sees a clean vector for the whole hold.
    drv_d = (state_d == StRun) ? vec_d : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      vec_q   <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= 4'd0;
      first_q <= 3'd0;
      pass_q  <= 1'b0;
      drv_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      drv_q   <= drv_d;
    end
  end

  assign bus.a          = drv_q[0];
  assign bus.b          = drv_q[1];
  assign bus.carryin    = drv_q[2];
  assign bus.busy       = (state_q == StRun);
  assign bus.done       = (state_q == StDone);
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = first_q;

endmodule

// File: tb/tb_full_adder_bist.sv
// Directed bench for full_adder_bist with a behavioural adder whose fault
// mode is selectable: 0 good, 1 carryout stuck at 0, 2 sum inverted.
module tb_full_adder_bist;
  localparam int S = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   mode = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  full_adder_bist_if bus ();

  full_adder_bist #(
    .SETTLE_CYCLES (S)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Adder under test
  assign bus.sum      = (bus.a ^ bus.b ^ bus.carryin) ^ (mode == 2);
  assign bus.carryout = (mode == 1) ? 1'b0 :
                        ((bus.a & bus.b) | (bus.a & bus.carryin) | (bus.b & bus.carryin));

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int drv();
    return 32'({bus.carryin, bus.b, bus.a});
  endfunction

  // Pulse start, follow the whole sweep, then check the results and the
  // cycle after done.
  task automatic run_sweep(input string tag, input int last_vec, input int exp_err,
                           input int exp_first, input int exp_pass, input int prev_pass);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < (last_vec + 1) * S; i++) begin
      check({tag, "/vec"}, drv(), i / S);
      check({tag, "/busy"}, 32'(bus.busy), 1);
      check({tag, "/done_early"}, 32'(bus.done), 0);
      check({tag, "/pass_hold"}, 32'(bus.pass), prev_pass);
      step();
    end
    check({tag, "/done"}, 32'(bus.done), 1);
    check({tag, "/busy_off"}, 32'(bus.busy), 0);
    check({tag, "/drv_off"}, drv(), 0);
    check({tag, "/err_count"}, 32'(bus.err_count), exp_err);
    check({tag, "/first_fail"}, 32'(bus.first_fail), exp_first);
    check({tag, "/pass"}, 32'(bus.pass), exp_pass);
    step();
    check({tag, "/done_pulse"}, 32'(bus.done), 0);
    check({tag, "/idle_busy"}, 32'(bus.busy), 0);
    check({tag, "/err_hold"}, 32'(bus.err_count), exp_err);
    check({tag, "/first_hold"}, 32'(bus.first_fail), exp_first);
    check({tag, "/pass_after"}, 32'(bus.pass), exp_pass);
  endtask

  initial begin
    bus.start = 1'b0;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Quiet after reset
    for (int i = 0; i < 50; i++) begin
      check("reset_quiet", 32'({bus.a, bus.b, bus.carryin, bus.busy, bus.done, bus.pass,
                                bus.err_count, bus.first_fail}), 0);
      step();
    end

    mode = 0;
    run_sweep("good", 7, 0, 0, 1, 0);

    mode = 1;
`ifdef FULL_ADDER_BIST_STOP_ON_FAIL_EN
    run_sweep("co_stuck0", 3, 1, 3, 0, 1);
`else
    run_sweep("co_stuck0", 7, 4, 3, 0, 1);
`endif

    mode = 2;
`ifdef FULL_ADDER_BIST_STOP_ON_FAIL_EN
    run_sweep("sum_inv", 0, 1, 0, 0, 0);
`else
    run_sweep("sum_inv", 7, 8, 0, 0, 0);
`endif

    // Second start mid-sweep is ignored; reset mid-sweep aborts without done.
    mode = 0;
    bus.start = 1'b1;
    step();                                    // after E0
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();        // after E0+4
    bus.start = 1'b1;
    step();                                    // after E0+5
    bus.start = 1'b0;
    check("restart_busy", 32'(bus.busy), 1);
    check("restart_vec", drv(), 1);
    for (int i = 0; i < 4; i++) step();        // after E0+9
    check("pre_reset_vec", drv(), 2);
    reset = 1'b1;
    step();                                    // after E0+10
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_drv", drv(), 0);
    check("abort_err", 32'(bus.err_count), 0);
    check("abort_pass", 32'(bus.pass), 0);
    for (int i = 0; i < 40; i++) begin
      check("abort_no_done", 32'({bus.busy, bus.done}), 0);
      step();
    end

    run_sweep("after_reset", 7, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
